// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store unit. It takes the access latched in EX/MEM, runs it
// as one request/ack transaction on the data bus, and hands the formatted load
// result to MEM/WB. While the access is in flight, `stall` freezes the
// pipeline.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles to wait for bus_ack before aborting (0 = never)
//
// Optional build macro:
//   MAU_MISALIGN_EN  rejects misaligned half/word accesses in IDLE. These
//                    accesses issue no bus cycle and pulse `misalign` with
//                    `done`.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       EX/MEM holds a load or store
//   dm_addr         byte address
//   dm_din          right-aligned store data
//   dm_we           1 = store, 0 = load
//   load_sel        funct3 size: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   bus_req/we      transaction request / write
//   bus_addr        word-aligned address
//   bus_wdata       lane-replicated store data
//   bus_wstrb       byte strobes (0 for loads)
//   bus_ack         one-cycle completion pulse from the slave
//   bus_rdata       read word, valid with bus_ack
//   dm_dout         formatted load result
//   done            one-cycle completion pulse
//   bus_err         one-cycle timeout pulse, coincident with done
//   misalign        misalignment pulse (MAU_MISALIGN_EN builds only)
//   stall           freeze all segment registers
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_din,
  input  logic        dm_we,
  input  logic [2:0]  load_sel,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] dm_dout,
  output logic        done,
  output logic        bus_err,
`ifdef MAU_MISALIGN_EN
  output logic        misalign,
`endif
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic        bus_req_reg,   bus_req_next;
  logic        bus_we_reg,    bus_we_next;
  logic [31:0] bus_addr_reg,  bus_addr_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic [3:0]  bus_wstrb_reg, bus_wstrb_next;
  logic [31:0] dm_dout_reg,   dm_dout_next;
  logic        bus_err_reg,   bus_err_next;
  // Size and byte offset of the access in flight. These are kept locally so
  // that load formatting does not depend on EX/MEM staying frozen.
  logic [2:0]  sel_reg,       sel_next;
  logic [1:0]  off_reg,       off_next;
  logic [31:0] tmo_cnt_reg,   tmo_cnt_next;
`ifdef MAU_MISALIGN_EN
  logic        misalign_reg,  misalign_next;
`endif

  // ---------------------------------------------------------------------------
  // Store formatting from the incoming request
  // ---------------------------------------------------------------------------
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    st_wdata = dm_din;
    st_wstrb = 4'b1111;
    case (load_sel[1:0])
      2'b00: begin
        st_wdata = {4{dm_din[7:0]}};
        st_wstrb = 4'b0001 << dm_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{dm_din[15:0]}};
        st_wstrb = 4'b0011 << {dm_addr[1], 1'b0};
      end
      default: begin
        st_wdata = dm_din;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MAU_MISALIGN_EN
  // Any size code other than byte or half is a word access.
  logic req_misaligned;
  always_comb begin
    req_misaligned = 1'b0;
    case (load_sel[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = dm_addr[0];
      default: req_misaligned = (dm_addr[1:0] != 2'b00);
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Load formatting of the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half [2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
      assign rd_byte[gi] = bus_rdata[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_half
      assign rd_half[gi] = bus_rdata[16*gi +: 16];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = rd_byte[off_reg];
    ld_half = rd_half[off_reg[1]];
    case (sel_reg)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // The counter value is the number of ack-less BUSY cycles already seen.
  // This cycle is the last one allowed when count + 1 reaches the limit.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_wstrb_next = bus_wstrb_reg;
    dm_dout_next   = dm_dout_reg;
    bus_err_next   = 1'b0;
    sel_next       = sel_reg;
    off_next       = off_reg;
    tmo_cnt_next   = tmo_cnt_reg;
`ifdef MAU_MISALIGN_EN
    misalign_next  = 1'b0;
`endif
    stall          = 1'b0;
    done           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Zero-cycle stall, so EX/MEM holds the request while it is accepted.
        stall = req_valid;
        if (req_valid) begin
`ifdef MAU_MISALIGN_EN
          if (req_misaligned) begin
            dm_dout_next  = 32'd0;
            misalign_next = 1'b1;
            state_next    = ST_DONE;
          end else begin
`endif
            bus_addr_next  = {dm_addr[31:2], 2'b00};
            bus_we_next    = dm_we;
            bus_wdata_next = st_wdata;
            bus_wstrb_next = dm_we ? st_wstrb : 4'b0000;
            bus_req_next   = 1'b1;
            sel_next       = load_sel;
            off_next       = dm_addr[1:0];
            tmo_cnt_next   = 32'd0;
            state_next     = ST_BUSY;
`ifdef MAU_MISALIGN_EN
          end
`endif
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        // An ack has priority over a timeout in the same cycle.
        if (bus_ack) begin
          if (!bus_we_reg) begin
            dm_dout_next = ld_data;
          end
          bus_req_next = 1'b0;
          state_next   = ST_DONE;
        end else if (timeout_hit) begin
          dm_dout_next = 32'd0;
          bus_err_next = 1'b1;
          bus_req_next = 1'b0;
          state_next   = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_cnt_next = tmo_cnt_reg + 32'd1;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'd0;
      bus_wdata_reg <= 32'd0;
      bus_wstrb_reg <= 4'd0;
      dm_dout_reg   <= 32'd0;
      bus_err_reg   <= 1'b0;
      sel_reg       <= 3'd0;
      off_reg       <= 2'd0;
      tmo_cnt_reg   <= 32'd0;
`ifdef MAU_MISALIGN_EN
      misalign_reg  <= 1'b0;
`endif
    end else begin
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_wstrb_reg <= bus_wstrb_next;
      dm_dout_reg   <= dm_dout_next;
      bus_err_reg   <= bus_err_next;
      sel_reg       <= sel_next;
      off_reg       <= off_next;
      tmo_cnt_reg   <= tmo_cnt_next;
`ifdef MAU_MISALIGN_EN
      misalign_reg  <= misalign_next;
`endif
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_wstrb = bus_wstrb_reg;
  assign dm_dout   = dm_dout_reg;
  assign bus_err   = bus_err_reg;
`ifdef MAU_MISALIGN_EN
  assign misalign  = misalign_reg;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with TIMEOUT_CYCLES = 4. Inputs change
// 1 ns after each rising edge, and outputs are sampled on the falling edge.
// "Cycle 0" is the IDLE cycle in which req_valid is first presented.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [2:0]  load_sel;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] dm_dout;
  logic        done;
  logic        bus_err;
  logic        stall;
`ifdef MAU_MISALIGN_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_we     (dm_we),
    .load_sel  (load_sel),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .dm_dout   (dm_dout),
    .done      (done),
    .bus_err   (bus_err),
`ifdef MAU_MISALIGN_EN
    .misalign  (misalign),
`endif
    .stall     (stall)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access. wait_n is the number of BUSY cycles without an ack;
  // the ack arrives in cycle wait_n+1 and done is expected in cycle wait_n+2.
  task automatic access(input string name, input logic [31:0] addr, input logic [31:0] din,
                        input logic we, input logic [2:0] sel, input int wait_n,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic [31:0] exp_dout);
    int e0;
    e0 = errors;
    next_cycle();
    req_valid = 1'b1; dm_addr = addr; dm_din = din; dm_we = we; load_sel = sel;
    bus_ack = 1'b0; bus_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check_val({name, " c0 stall"}, {31'd0, stall}, 32'd1);
    check_val({name, " c0 bus_req"}, {31'd0, bus_req}, 32'd0);
    for (int i = 1; i <= wait_n + 1; i++) begin
      next_cycle();
      bus_ack   = (i == wait_n + 1);
      bus_rdata = bus_ack ? rdata : 32'h5555_5555;
      @(negedge clk);
      check_val({name, " busy stall"}, {31'd0, stall}, 32'd1);
      check_val({name, " busy bus_req"}, {31'd0, bus_req}, 32'd1);
      check_val({name, " busy done"}, {31'd0, done}, 32'd0);
      if (i == 1) begin
        check_val({name, " bus_addr"}, bus_addr, exp_addr);
        check_val({name, " bus_we"}, {31'd0, bus_we}, {31'd0, we});
        check_val({name, " bus_wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_wstrb});
        if (we) check_val({name, " bus_wdata"}, bus_wdata, exp_wdata);
      end
    end
    next_cycle();
    bus_ack = 1'b0; bus_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check_val({name, " done"}, {31'd0, done}, 32'd1);
    check_val({name, " done stall"}, {31'd0, stall}, 32'd0);
    check_val({name, " done bus_req"}, {31'd0, bus_req}, 32'd0);
    check_val({name, " done bus_err"}, {31'd0, bus_err}, 32'd0);
    check_val({name, " dm_dout"}, dm_dout, exp_dout);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check_val({name, " idle done"}, {31'd0, done}, 32'd0);
    check_val({name, " idle stall"}, {31'd0, stall}, 32'd0);
    $display("txn %-10s addr=0x%08h we=%0d sel=%03b waits=%0d dout=0x%08h %s",
             name, addr, we, sel, wait_n, dm_dout, (errors == e0) ? "ok" : "bad");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; dm_addr = 32'd0; dm_din = 32'd0; dm_we = 1'b0;
    load_sel = 3'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rst bus_we", {31'd0, bus_we}, 32'd0);
    check_val("rst bus_addr", bus_addr, 32'd0);
    check_val("rst bus_wdata", bus_wdata, 32'd0);
    check_val("rst bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    check_val("rst dm_dout", dm_dout, 32'd0);
    check_val("rst done", {31'd0, done}, 32'd0);
    check_val("rst bus_err", {31'd0, bus_err}, 32'd0);
    check_val("rst stall", {31'd0, stall}, 32'd0);
`ifdef MAU_MISALIGN_EN
    check_val("rst misalign", {31'd0, misalign}, 32'd0);
`endif
    $display("txn reset      outputs cleared");

    //      name        addr          din           we    sel     w  rdata         exp_addr      exp_wdata     strb     exp_dout
    access("lw",       32'h0000_0100, 32'h0,        1'b0, 3'b010, 0, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF);
    access("lb",       32'h0000_0103, 32'h0,        1'b0, 3'b000, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80);
    access("lbu",      32'h0000_0103, 32'h0,        1'b0, 3'b100, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0080);
    access("lh",       32'h0000_0102, 32'h0,        1'b0, 3'b001, 1, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_80FF);
    access("lhu",      32'h0000_0100, 32'h0,        1'b0, 3'b101, 0, 32'h80FF_8001, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_8001);
    access("lb+",      32'h0000_0101, 32'h0,        1'b0, 3'b000, 0, 32'h80FF_7F00, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_007F);
    access("sh",       32'h0000_0202, 32'h1234_ABCD, 1'b1, 3'b001, 0, 32'hFFFF_FFFF, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0000_007F);
    access("sb",       32'h0000_0301, 32'h0000_00A5, 1'b1, 3'b000, 2, 32'hFFFF_FFFF, 32'h0000_0300, 32'hA5A5_A5A5, 4'b0010, 32'h0000_007F);
    access("sw",       32'h0000_040C, 32'hCAFE_F00D, 1'b1, 3'b010, 0, 32'hFFFF_FFFF, 32'h0000_040C, 32'hCAFE_F00D, 4'b1111, 32'h0000_007F);
    // Ack arrives in the same cycle the timeout would fire: the ack wins.
    access("lw ackto", 32'h0000_0500, 32'h0,        1'b0, 3'b010, 3, 32'h1234_5678, 32'h0000_0500, 32'h0,        4'b0000, 32'h1234_5678);
    access("lw sel11", 32'h0000_0104, 32'h0,        1'b0, 3'b011, 0, 32'h0BAD_C0DE, 32'h0000_0104, 32'h0,        4'b0000, 32'h0BAD_C0DE);
    access("lhu hi",   32'h0000_0106, 32'h0,        1'b0, 3'b101, 0, 32'hF00D_1234, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_F00D);

`ifdef MAU_MISALIGN_EN
    // Misaligned word load: no bus cycle, done and misalign in cycle 1.
    next_cycle();
    req_valid = 1'b1; dm_addr = 32'h0000_0101; dm_we = 1'b0; load_sel = 3'b010;
    @(negedge clk);
    check_val("mis c0 stall", {31'd0, stall}, 32'd1);
    next_cycle();
    @(negedge clk);
    check_val("mis bus_req", {31'd0, bus_req}, 32'd0);
    check_val("mis done", {31'd0, done}, 32'd1);
    check_val("mis misalign", {31'd0, misalign}, 32'd1);
    check_val("mis dm_dout", dm_dout, 32'd0);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check_val("mis misalign clr", {31'd0, misalign}, 32'd0);
    $display("txn lw mis    addr=0x00000101 misaligned, no bus cycle");
`else
    access("lw 0x101", 32'h0000_0101, 32'h0,        1'b0, 3'b010, 0, 32'h1122_3344, 32'h0000_0100, 32'h0,        4'b0000, 32'h1122_3344);
`endif

    // Timeout: no ack at all; bus_req in cycles 1-4, done/bus_err in cycle 5.
    next_cycle();
    req_valid = 1'b1; dm_addr = 32'h0000_0700; dm_we = 1'b0; load_sel = 3'b010;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("tmo c0 stall", {31'd0, stall}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      @(negedge clk);
      check_val("tmo bus_req", {31'd0, bus_req}, 32'd1);
      check_val("tmo done early", {31'd0, done}, 32'd0);
    end
    next_cycle();
    @(negedge clk);
    check_val("tmo done", {31'd0, done}, 32'd1);
    check_val("tmo bus_err", {31'd0, bus_err}, 32'd1);
    check_val("tmo dm_dout", dm_dout, 32'd0);
    check_val("tmo bus_req", {31'd0, bus_req}, 32'd0);
    check_val("tmo stall", {31'd0, stall}, 32'd0);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check_val("tmo bus_err clr", {31'd0, bus_err}, 32'd0);
    $display("txn timeout   addr=0x00000700 bus_err after %0d cycles", TMO);

    // Give dm_dout a nonzero value so that the reset is seen to clear it.
    access("lw pre",   32'h0000_0800, 32'h0,        1'b0, 3'b010, 0, 32'h5A5A_1234, 32'h0000_0800, 32'h0,        4'b0000, 32'h5A5A_1234);

    // Reset in the 3rd BUSY wait cycle.
    next_cycle();
    req_valid = 1'b1; dm_addr = 32'h0000_0600; dm_we = 1'b0; load_sel = 3'b010;
    @(negedge clk);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_val("rstmid busy", {31'd0, bus_req}, 32'd1);
    next_cycle();
    rst = 1'b1; req_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_val("rstmid bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rstmid stall", {31'd0, stall}, 32'd0);
    check_val("rstmid done", {31'd0, done}, 32'd0);
    check_val("rstmid dm_dout", dm_dout, 32'd0);
    check_val("rstmid bus_addr", bus_addr, 32'd0);
    // A stray ack in IDLE must be ignored.
    next_cycle();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    next_cycle();
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("stray ack done", {31'd0, done}, 32'd0);
    check_val("stray ack dout", dm_dout, 32'd0);
    check_val("stray ack req", {31'd0, bus_req}, 32'd0);
    $display("txn rst mid   outputs cleared, stray ack ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
